// File: rtl/dsp_acc_pkg.sv
// Shared types, defaults and the saturating adder for the product accumulator.
// The adder works on a 64-bit container, so ACC_WIDTH is limited to 64.
package dsp_acc_pkg;

   localparam int unsigned P_WIDTH_DEF   = 16;
   localparam int unsigned ACC_WIDTH_DEF = 40;
   localparam int unsigned COUNT_WIDTH   = 16;

   typedef logic [COUNT_WIDTH-1:0] count_t;

   typedef enum logic {
      SLOT_EMPTY,
      SLOT_FULL
   } slot_state_t;

   // Returns {sum[63:0], overflow}; only the low 'width' bits of sum are meaningful.
   function automatic logic [64:0] sat_add(input logic [63:0]  acc,
                                           input logic [63:0]  ext_p,
                                           input int unsigned  width,
                                           input bit           is_signed,
                                           input bit           saturate);
      logic [63:0] mask;
      logic [63:0] msb;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] sum;
      logic [63:0] max_v;
      logic [63:0] min_v;
      logic [64:0] full;
      logic        ovf;
      logic        sa;
      logic        sb;
      logic        ss;
      mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
      msb  = 64'd1 << (width - 1);
      a    = acc & mask;
      b    = ext_p & mask;
      full = {1'b0, a} + {1'b0, b};
      sum  = full[63:0] & mask;
      sa   = |(a & msb);
      sb   = |(b & msb);
      ss   = |(sum & msb);
      if (is_signed) begin
         ovf   = (sa == sb) && (ss != sa);
         max_v = mask >> 1;
         min_v = mask & ~(mask >> 1);
      end else begin
         ovf   = |(full & (65'd1 << width));
         max_v = mask;
         min_v = '0;
      end
      if (ovf && saturate) begin
         sum = (is_signed && sa) ? min_v : max_v;
      end
      return {sum, ovf};
   endfunction

endpackage

// File: rtl/dsp_acc_out_slot.sv
// One-entry registered result slot with valid/ready and upstream ready generation.
module dsp_acc_out_slot
   import dsp_acc_pkg::*;
#(
   parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_i,
   input  logic [ACC_WIDTH-1:0] acc_i,
   input  count_t               count_i,
   input  logic                 ovf_i,
   input  logic                 out_ready_i,
   output logic                 out_valid_o,
   output logic                 in_ready_o,
   output logic [ACC_WIDTH-1:0] acc_o,
   output count_t               count_o,
   output logic                 ovf_o
);

   slot_state_t          state_q, state_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   count_t               count_q, count_d;
   logic                 ovf_q, ovf_d;

   assign out_valid_o = (state_q == SLOT_FULL);
   assign in_ready_o  = (state_q == SLOT_EMPTY) || out_ready_i;
   assign acc_o       = acc_q;
   assign count_o     = count_q;
   assign ovf_o       = ovf_q;

   // load_i only arrives when in_ready_o is high, so a FULL slot loading is always draining too.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (load_i) begin
         state_d = SLOT_FULL;
         acc_d   = acc_i;
         count_d = count_i;
         ovf_d   = ovf_i;
      end else if (state_q == SLOT_FULL && out_ready_i) begin
         state_d = SLOT_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= SLOT_EMPTY;
         acc_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: rtl/dsp_product_accumulator.sv
// Per-frame accumulator of multiplier products with optional saturation; one result per frame.
module dsp_product_accumulator
   import dsp_acc_pkg::*;
#(
   parameter int unsigned P_WIDTH   = P_WIDTH_DEF,
   parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF,
   parameter bit          SIGNED    = 1'b0,
   parameter bit          SATURATE  = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [P_WIDTH-1:0]   in_p,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_acc,
   output logic [15:0]          out_count,
   output logic                 out_overflow
);

   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   count_t               count_q, count_d;
   logic                 ovf_q, ovf_d;

   logic [ACC_WIDTH-1:0] ext_p;
   logic [64:0]          add_res;
   logic [ACC_WIDTH-1:0] sum;
   logic                 add_ovf;
   logic                 unused_add_bits;
   count_t               count_inc;
   logic                 accept;
   logic                 frame_done;

   assign ext_p = SIGNED ? {{(ACC_WIDTH-P_WIDTH){in_p[P_WIDTH-1]}}, in_p}
                         : {{(ACC_WIDTH-P_WIDTH){1'b0}}, in_p};

   assign add_res         = sat_add(64'(acc_q), 64'(ext_p), ACC_WIDTH, SIGNED, SATURATE);
   assign sum             = add_res[ACC_WIDTH:1];
   assign add_ovf         = add_res[0];
   assign unused_add_bits = ^add_res;

   assign count_inc  = (count_q == '1) ? count_q : count_q + count_t'(1);
   assign accept     = in_valid && in_ready;
   assign frame_done = accept && in_last;

   always_comb begin
      acc_d   = acc_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (accept) begin
         if (in_last) begin
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
         end else begin
            acc_d   = sum;
            count_d = count_inc;
            ovf_d   = ovf_q | add_ovf;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   dsp_acc_out_slot #(
      .ACC_WIDTH (ACC_WIDTH)
   ) u_out_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (frame_done),
      .acc_i       (sum),
      .count_i     (count_inc),
      .ovf_i       (ovf_q | add_ovf),
      .out_ready_i (out_ready),
      .out_valid_o (out_valid),
      .in_ready_o  (in_ready),
      .acc_o       (out_acc),
      .count_o     (out_count),
      .ovf_o       (out_overflow)
   );

endmodule

// File: tb/tb_dsp_product_accumulator.sv
// Scoreboard bench: four accumulator configurations, directed frames with hand-computed sums.
module tb_dsp_product_accumulator;

   // inst 0: unsigned/sat/40, inst 1: signed/sat/40, inst 2: unsigned/sat/17, inst 3: unsigned/wrap/17
   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  iv, ir, ilast, ordy, ov, oovf;
   logic [15:0] ip   [4];
   logic [39:0] oacc [4];
   logic [15:0] ocnt [4];

   typedef struct {
      int          id;
      logic [39:0] acc;
      logic [15:0] cnt;
      logic        ovf;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int unsigned AW = (g >= 2) ? 17 : 40;
      logic [AW-1:0] acc_w;
      dsp_product_accumulator #(
         .P_WIDTH   (16),
         .ACC_WIDTH (AW),
         .SIGNED    (g == 1),
         .SATURATE  (g != 3)
      ) u_dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .in_valid     (iv[g]),
         .in_ready     (ir[g]),
         .in_p         (ip[g]),
         .in_last      (ilast[g]),
         .out_valid    (ov[g]),
         .out_ready    (ordy[g]),
         .out_acc      (acc_w),
         .out_count    (ocnt[g]),
         .out_overflow (oovf[g])
      );
      assign oacc[g] = 40'(acc_w);
   end

   function automatic void check(string name, logic [39:0] got, logic [39:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endfunction

   task automatic push(int id, logic [39:0] a, logic [15:0] c, logic o);
      exp_t e;
      e.id  = id;
      e.acc = a;
      e.cnt = c;
      e.ovf = o;
      sb_q.push_back(e);
   endtask

   task automatic send(int id, logic [15:0] p, logic last);
      int unsigned waited = 0;
      iv[id]    = 1'b1;
      ip[id]    = p;
      ilast[id] = last;
      @(negedge clk);
      while (!ir[id] && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!ir[id]) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: inst %0d never ready, beat %0h", id, p);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int id);
      iv[id]    = 1'b0;
      ilast[id] = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 4; i++) begin
            if (ov[i] && ordy[i]) begin
               if (sb_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_result: inst %0d acc %0h, nothing expected", i, oacc[i]);
               end else begin
                  exp_t e;
                  e = sb_q.pop_front();
                  check("result_inst", 40'(i), 40'(e.id));
                  check("out_acc", oacc[i], e.acc);
                  check("out_count", 40'(ocnt[i]), 40'(e.cnt));
                  check("out_overflow", 40'(oovf[i]), 40'(e.ovf));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      iv    = '0;
      ilast = '0;
      ordy  = '1;
      for (int i = 0; i < 4; i++) ip[i] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check("rst_out_valid", 40'(ov[i]), 40'd0);
         check("rst_out_acc", oacc[i], 40'd0);
         check("rst_out_count", 40'(ocnt[i]), 40'd0);
         check("rst_out_overflow", 40'(oovf[i]), 40'd0);
         check("rst_in_ready", 40'(ir[i]), 40'd1);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;

      // basic unsigned frame and output latency
      send(0, 16'd100, 1'b0);
      send(0, 16'd200, 1'b0);
      check("no_early_valid", 40'(ov[0]), 40'd0);
      push(0, 40'd600, 16'd3, 1'b0);
      send(0, 16'd300, 1'b1);
      check("latency_valid", 40'(ov[0]), 40'd1);
      idle(0);
      @(posedge clk);
      @(negedge clk);
      check("drained_valid", 40'(ov[0]), 40'd0);
      @(posedge clk);
      #1;

      // signed frame: -1 + 2 - 32768
      push(1, 40'hFF_FFFF_8001, 16'd3, 1'b0);
      send(1, 16'hFFFF, 1'b0);
      send(1, 16'h0002, 1'b0);
      send(1, 16'h8000, 1'b1);
      idle(1);

      // 17-bit saturate and wrap, then a clean frame
      push(2, 40'h1FFFF, 16'd3, 1'b1);
      send(2, 16'hFFFF, 1'b0);
      send(2, 16'hFFFF, 1'b0);
      send(2, 16'hFFFF, 1'b1);
      push(2, 40'd5, 16'd1, 1'b0);
      send(2, 16'd5, 1'b1);
      idle(2);
      push(3, 40'h0FFFD, 16'd3, 1'b1);
      send(3, 16'hFFFF, 1'b0);
      send(3, 16'hFFFF, 1'b0);
      send(3, 16'hFFFF, 1'b1);
      push(3, 40'd5, 16'd1, 1'b0);
      send(3, 16'd5, 1'b1);
      idle(3);
      repeat (2) @(posedge clk);
      #1;

      // backpressure: frame A held while frame B's first beat is offered
      ordy[0] = 1'b0;
      push(0, 40'd10, 16'd2, 1'b0);
      send(0, 16'd4, 1'b0);
      send(0, 16'd6, 1'b1);
      iv[0]    = 1'b1;
      ip[0]    = 16'd5;
      ilast[0] = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("stall_in_ready", 40'(ir[0]), 40'd0);
         check("stall_valid", 40'(ov[0]), 40'd1);
         check("stall_hold_acc", oacc[0], 40'd10);
      end
      @(posedge clk);
      #1 ordy[0] = 1'b1;
      push(0, 40'd11, 16'd2, 1'b0);
      send(0, 16'd5, 1'b0);
      send(0, 16'd6, 1'b1);
      idle(0);
      @(posedge clk);
      #1;

      // back-to-back single-beat frames at full rate
      for (int k = 1; k <= 4; k++) begin
         push(0, 40'(k), 16'd1, 1'b0);
         send(0, 16'(k), 1'b1);
         check("b2b_valid", 40'(ov[0]), 40'd1);
         check("b2b_acc", oacc[0], 40'(k));
      end
      idle(0);
      @(posedge clk);
      #1;

      // reset mid-frame discards the partial sum
      send(0, 16'd3, 1'b0);
      send(0, 16'd5, 1'b0);
      idle(0);
      rst_n = 1'b0;
      @(negedge clk);
      check("valid_in_reset", 40'(ov[0]), 40'd0);
      @(posedge clk);
      #1;
      check("valid_after_reset", 40'(ov[0]), 40'd0);
      rst_n = 1'b1;
      push(0, 40'd7, 16'd1, 1'b0);
      send(0, 16'd7, 1'b1);
      idle(0);

      for (int w = 0; w < 50 && sb_q.size() != 0; w++) @(posedge clk);
      @(negedge clk);
      check("scoreboard_drain", 40'(sb_q.size()), 40'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
